// File: rtl/uart_pkg.sv
// Shared state encoding, parity modes and parity helper for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_EVEN   = 1;
  localparam int PARITY_ODD    = 2;
  localparam int MAX_DATA_BITS = 9;

  // Expected parity bit for a zero-extended data word.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversampling counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OSR = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic s_tick,
  input  logic rx,
  input  logic start_det,
  input  logic run,
  output logic rx_s,
  output logic bit_val,
  output logic bit_strobe,
  output logic bit_end
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] T_V0   = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] T_V1   = TW'(OSR/2);
  localparam logic [TW-1:0] T_V2   = TW'(OSR/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);

  logic [1:0]    sync_q, sync_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    vote_q, vote_d;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], rx};
    vote_d     = vote_q;
    tick_cnt_d = tick_cnt_q;
    // The start-detect tick counts as tick 0 of the start bit.
    if (start_det) begin
      tick_cnt_d = TW'(1);
    end else if (!run) begin
      tick_cnt_d = '0;
    end else if (s_tick) begin
      tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
    end
    if (s_tick && (tick_cnt_q == T_V0)) vote_d[0] = rx_s;
    if (s_tick && (tick_cnt_q == T_V1)) vote_d[1] = rx_s;
  end

  assign bit_strobe = s_tick && (tick_cnt_q == T_V2);
  assign bit_end    = s_tick && (tick_cnt_q == T_LAST);
  assign bit_val    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      vote_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      vote_q     <= vote_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: framing FSM, shift register and read/overrun status.
// Define UART_RX_BREAK_DET_EN to add break detection and the brk output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rx_re,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic [2:0]           rx_state,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 brk
`endif
);

  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_e                state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic                     p_err_q, p_err_d;
  logic                     f_err_q, f_err_d;
  logic [DATA_BITS-1:0]     rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic [MAX_DATA_BITS-1:0] shift_ext;
  logic                     rx_s, bit_val, bit_strobe, bit_end;
  logic                     start_det, frame_done, brk_frame, deliver, rd, last_stop, parked;

  uart_rx_sampler #(.OSR(OSR)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .s_tick     (s_tick),
    .rx         (rx),
    .start_det  (start_det),
    .run        (state_q != RX_IDLE),
    .rx_s       (rx_s),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  assign start_det = (state_q == RX_IDLE) && s_tick && !rx_s && !parked;
  assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

  always_comb begin
    shift_ext                  = '0;
    shift_ext[DATA_BITS-1:0]   = shift_q;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    p_err_d    = p_err_q;
    f_err_d    = f_err_q;
    frame_done = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (start_det) begin
          state_d = RX_START;
          p_err_d = 1'b0;
          f_err_d = 1'b0;
        end
      end
      RX_START: begin
        if (bit_strobe && bit_val) begin
          state_d = RX_IDLE;
        end else if (bit_end) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        if (bit_strobe) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == BW'(i)) shift_d[i] = bit_val;
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (bit_end && (bit_cnt_q == BW'(DATA_BITS))) begin
          state_d    = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      RX_PARITY: begin
        if (bit_strobe) p_err_d = (bit_val != parity_bit(shift_ext, PARITY));
        if (bit_end) begin
          state_d    = RX_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      RX_STOP: begin
        // Finish at the last stop bit's vote point so a back-to-back start edge is caught.
        if (bit_strobe) begin
          if (!bit_val) f_err_d = 1'b1;
          if (last_stop) begin
            frame_done = 1'b1;
            state_d    = RX_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rd      = rx_re && rx_valid_q;
  assign deliver = frame_done && !brk_frame;

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (rd) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
    if (deliver) begin
      if (!rx_valid_q || rd) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        parity_err_d = p_err_q;
        frame_err_d  = f_err_d;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      p_err_q      <= 1'b0;
      f_err_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      p_err_q      <= p_err_d;
      f_err_q      <= f_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  localparam int TW = $clog2(OSR);

  logic          all_zero_q, all_zero_d;
  logic          park_q, park_d;
  logic          brk_q, brk_d;
  logic [TW-1:0] high_cnt_q, high_cnt_d;

  assign parked    = park_q;
  assign brk_frame = frame_done && all_zero_d;
  assign brk       = brk_q;

  always_comb begin
    all_zero_d = all_zero_q;
    if (start_det) begin
      all_zero_d = 1'b1;
    end else if (bit_strobe && bit_val && (state_q inside {RX_DATA, RX_PARITY, RX_STOP})) begin
      all_zero_d = 1'b0;
    end
  end

  // After a break, stay idle until the line has been high for a whole bit time.
  always_comb begin
    park_d     = park_q;
    high_cnt_d = high_cnt_q;
    brk_d      = brk_q;
    if (rx_re) brk_d = 1'b0;
    if (brk_frame) begin
      brk_d      = 1'b1;
      park_d     = 1'b1;
      high_cnt_d = '0;
    end else if (park_q && s_tick) begin
      if (!rx_s) begin
        high_cnt_d = '0;
      end else if (high_cnt_q == TW'(OSR - 1)) begin
        park_d     = 1'b0;
        high_cnt_d = '0;
      end else begin
        high_cnt_d = high_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      all_zero_q <= 1'b0;
      park_q     <= 1'b0;
      brk_q      <= 1'b0;
      high_cnt_q <= '0;
    end else begin
      all_zero_q <= all_zero_d;
      park_q     <= park_d;
      brk_q      <= brk_d;
      high_cnt_q <= high_cnt_d;
    end
  end
`else
  assign parked    = 1'b0;
  assign brk_frame = 1'b0;
`endif

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_busy    = (state_q != RX_IDLE);
  assign rx_state   = state_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E2 instance driven with directed and random frames.
// Build with UART_RX_BREAK_DET_EN defined to also exercise break detection.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int OSR      = 16;
  localparam int TICK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst, s_tick;
  logic       rx0, rx1, re0, re1;
  logic [7:0] data0, data1;
  logic       valid0, busy0, perr0, ferr0, ovr0;
  logic       valid1, busy1, perr1, ferr1, ovr1;
  logic [2:0] st0, st1;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk0, brk1;
  logic       m_brk [2];
`endif

  // Reference model: what the register interface should show per instance.
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  logic       m_perr  [2];
  logic       m_ferr  [2];
  logic       m_ovr   [2];

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_core #(.OSR(OSR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx0), .rx_re(re0),
    .rx_data(data0), .rx_valid(valid0), .rx_busy(busy0), .rx_state(st0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk0)
`endif
  );

  uart_rx_core #(.OSR(OSR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx1), .rx_re(re1),
    .rx_data(data1), .rx_valid(valid1), .rx_busy(busy1), .rx_state(st1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk1)
`endif
  );

  initial begin
    int div;
    div    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (div == 0);
      div    = (div + 1) % TICK_DIV;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input int w, input logic v, input int nticks);
    @(negedge clk);
    if (w == 0) rx0 = v; else rx1 = v;
    wait_ticks(nticks);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_valid[w] = 1'b0; m_data[w] = 8'h00; m_perr[w] = 1'b0;
      m_ferr[w]  = 1'b0; m_ovr[w]  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      m_brk[w] = 1'b0;
`endif
    end
  endtask

  task automatic model_frame(input int w, input logic [7:0] d, input logic pe, input logic fe,
                             input logic is_brk);
`ifdef UART_RX_BREAK_DET_EN
    if (is_brk) begin
      m_brk[w] = 1'b1;
      return;
    end
`endif
    if (!m_valid[w]) begin
      m_valid[w] = 1'b1; m_data[w] = d; m_perr[w] = pe; m_ferr[w] = fe;
    end else begin
      m_ovr[w] = 1'b1;
    end
  endtask

  task automatic model_read(input int w);
    if (m_valid[w]) begin
      m_valid[w] = 1'b0; m_perr[w] = 1'b0; m_ferr[w] = 1'b0; m_ovr[w] = 1'b0;
    end
`ifdef UART_RX_BREAK_DET_EN
    m_brk[w] = 1'b0;
`endif
  endtask

  task automatic check_state(input int w, input string tag);
    logic       g_valid, g_perr, g_ferr, g_ovr, g_busy;
    logic [7:0] g_data;
    logic [2:0] g_st;
    if (w == 0) begin
      g_valid = valid0; g_perr = perr0; g_ferr = ferr0; g_ovr = ovr0;
      g_busy  = busy0;  g_data = data0; g_st   = st0;
    end else begin
      g_valid = valid1; g_perr = perr1; g_ferr = ferr1; g_ovr = ovr1;
      g_busy  = busy1;  g_data = data1; g_st   = st1;
    end
    check({tag, ".valid"}, g_valid, m_valid[w]);
    check({tag, ".data"},  g_data,  m_data[w]);
    check({tag, ".perr"},  g_perr,  m_perr[w]);
    check({tag, ".ferr"},  g_ferr,  m_ferr[w]);
    check({tag, ".ovr"},   g_ovr,   m_ovr[w]);
    check({tag, ".busy"},  g_busy,  1'b0);
    check({tag, ".state"}, g_st,    3'd0);
`ifdef UART_RX_BREAK_DET_EN
    check({tag, ".brk"}, (w == 0) ? brk0 : brk1, m_brk[w]);
`endif
  endtask

  // Instance 0 is 8N1, instance 1 is 8E2; stops[i] is the level driven on stop bit i.
  task automatic send_frame(input int w, input logic [7:0] d, input logic par, input logic [1:0] stops);
    logic has_par, exp_perr, exp_ferr, is_brk;
    int   nstop;
    has_par = (w == 1);
    nstop   = (w == 1) ? 2 : 1;
    drive_bit(w, 1'b0, OSR);
    for (int b = 0; b < 8; b++) drive_bit(w, d[b], OSR);
    if (has_par) drive_bit(w, par, OSR);
    for (int s = 0; s < nstop; s++) drive_bit(w, stops[s], OSR);
    drive_bit(w, 1'b1, 2*OSR);
    exp_perr = has_par && (par != (^d));
    exp_ferr = (nstop == 2) ? !(stops[0] && stops[1]) : !stops[0];
    is_brk   = (d == 8'h00) && (!has_par || !par) && ((nstop == 2) ? (stops == 2'b00) : !stops[0]);
    $display("frame dut=%0d data=0x%02h par=%0b stops=%02b perr=%0b ferr=%0b brk=%0b",
             w, d, par, stops, exp_perr, exp_ferr, is_brk);
    model_frame(w, d, exp_perr, exp_ferr, is_brk);
    check_state(w, $sformatf("frame%0d_%02h", w, d));
  endtask

  task automatic do_read(input int w);
    @(negedge clk);
    if (w == 0) re0 = 1'b1; else re1 = 1'b1;
    @(negedge clk);
    if (w == 0) re0 = 1'b0; else re1 = 1'b0;
    model_read(w);
    $display("read dut=%0d", w);
    check_state(w, $sformatf("read%0d", w));
  endtask

  initial begin
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; re0 = 1'b0; re1 = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
    check_state(0, "reset0");
    check_state(1, "reset1");

    send_frame(0, 8'hA5, 1'b0, 2'b11);
    do_read(0);

    send_frame(1, 8'h07, 1'b0, 2'b11);
    do_read(1);
    send_frame(1, 8'h07, 1'b1, 2'b11);
    do_read(1);

    drive_bit(0, 1'b0, 3);
    @(negedge clk);
    $display("glitch dut=0 low for 3 ticks");
    check("glitch.busy", busy0, 1'b1);
    drive_bit(0, 1'b1, 2*OSR);
    check_state(0, "glitch");

    send_frame(0, 8'h11, 1'b0, 2'b11);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    do_read(0);

    send_frame(0, 8'h3C, 1'b0, 2'b00);
    do_read(0);

    drive_bit(0, 1'b0, OSR);
    drive_bit(0, 1'b1, OSR);
    drive_bit(0, 1'b0, OSR/2);
    @(negedge clk);
    check("midrst.busy", busy0, 1'b1);
    rst = 1'b1; rx0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("reset mid-frame");
    check_state(0, "midrst");
    drive_bit(0, 1'b1, 2*OSR);
    send_frame(0, 8'h55, 1'b0, 2'b11);
    do_read(0);

`ifdef UART_RX_BREAK_DET_EN
    drive_bit(0, 1'b0, 20*OSR);
    m_brk[0] = 1'b1;
    $display("break dut=0 line low for two frames");
    check_state(0, "break");
    drive_bit(0, 1'b1, OSR);
    send_frame(0, 8'h81, 1'b0, 2'b11);
    do_read(0);
`endif

    for (int n = 0; n < 30; n++) begin
      int         w;
      logic [7:0] d;
      logic       p;
      logic [1:0] st;
      w  = int'($urandom_range(0, 1));
      d  = 8'($urandom);
      p  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      send_frame(w, d, p, st);
      if ($urandom_range(0, 2) != 0) do_read(w);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
